// File: rtl/bus2_arbiter.sv
// Round-robin arbiter that shares one bus2 memory channel between the I-cache (port 0)
// and the D-cache (port 1), sequencing full-line reads/writes with a response timeout.
module bus2_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            wtake,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rvalid,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [1:0]            m_cmd,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_resp
);

  localparam int BCNT_W = $clog2(BEATS) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [BCNT_W-1:0] ALL_BEATS = BCNT_W'(BEATS);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WDATA,
    S_WRESP,
    S_RDATA,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_last;
  logic                r_err;

  state_t              w_state_next;
  logic                w_owner_next;
  logic                w_we_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [BCNT_W-1:0]   w_beat_cnt_next;
  logic [TMO_W-1:0]    w_tmo_cnt_next;
  logic                w_last_next;
  logic                w_err_next;

  logic [ADDR_W-1:0]   w_port_addr  [2];
  logic [DATA_W-1:0]   w_port_wdata [2];
  logic                w_sel;
  logic [BCNT_W-1:0]   w_beat_inc;
  logic [TMO_W-1:0]    w_tmo_inc;
  logic                w_tmo_hit;
  logic                w_busy;
  logic                w_send;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign w_port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign w_port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Contention goes to the port that did not own the previous transaction.
  assign w_sel      = (req == 2'b11) ? ~r_last : req[1];
  assign w_beat_inc = r_beat_cnt + 1'b1;
  assign w_tmo_inc  = r_tmo_cnt + 1'b1;
  assign w_tmo_hit  = (w_tmo_inc == TMO_MAX);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_beat_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_last     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_tmo_cnt  <= w_tmo_cnt_next;
      r_last     <= w_last_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_we_next       = r_we;
    w_addr_next     = r_addr;
    w_beat_cnt_next = r_beat_cnt;
    w_tmo_cnt_next  = r_tmo_cnt;
    w_last_next     = r_last;
    w_err_next      = r_err;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_next = w_sel;
          w_we_next    = we[w_sel];
          w_addr_next  = w_port_addr[w_sel];
          w_state_next = S_ISSUE;
        end
      end

      // The ISSUE cycle is the first counted cycle, so DONE lands exactly
      // TIMEOUT cycles after the command when memory stays silent.
      S_ISSUE: begin
        w_tmo_cnt_next = w_tmo_inc;
        if (r_we) begin
          w_beat_cnt_next = BCNT_W'(1);
          w_state_next    = S_WDATA;
        end else begin
          w_state_next    = S_RDATA;
        end
      end

      S_WDATA: begin
        w_tmo_cnt_next  = w_tmo_inc;
        w_beat_cnt_next = w_beat_inc;
        if (w_tmo_hit) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end else if (r_beat_cnt == LAST_BEAT) begin
          w_state_next = S_WRESP;
        end
      end

      S_WRESP: begin
        w_tmo_cnt_next = w_tmo_inc;
        if (m_resp) begin
          w_state_next = S_DONE;
        end else if (w_tmo_hit) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end
      end

      // A beat arriving on the timeout cycle still completes the line cleanly.
      S_RDATA: begin
        w_tmo_cnt_next = w_tmo_inc;
        if (m_rvalid) begin
          w_beat_cnt_next = w_beat_inc;
        end
        if (m_rvalid && (w_beat_inc == ALL_BEATS)) begin
          w_state_next = S_DONE;
        end else if (w_tmo_hit) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_last_next     = r_owner;
        w_beat_cnt_next = '0;
        w_tmo_cnt_next  = '0;
        w_err_next      = 1'b0;
        w_state_next    = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state != S_IDLE);
  assign w_send = ((r_state == S_ISSUE) && r_we) || (r_state == S_WDATA);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port_out
      logic w_own;
      assign w_own      = w_busy && (r_owner == 1'(gi));
      assign gnt[gi]    = w_own;
      assign wtake[gi]  = w_own && w_send;
      assign rvalid[gi] = w_own && (r_state == S_RDATA) && m_rvalid;
      assign done[gi]   = w_own && (r_state == S_DONE);
      assign err[gi]    = w_own && (r_state == S_DONE) && r_err;
    end
  endgenerate

  always_comb begin
    m_cmd   = CMD_NOP;
    m_addr  = '0;
    m_wdata = '0;
    rdata   = '0;
    if (r_state == S_ISSUE) begin
      m_cmd  = r_we ? CMD_WRITE : CMD_READ;
      m_addr = r_addr;
    end
    if (w_send) begin
      m_wdata = w_port_wdata[r_owner];
    end
    if ((r_state == S_RDATA) && m_rvalid) begin
      rdata = m_rdata;
    end
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Scoreboard bench for bus2_arbiter: expected commands, beats and completions are queued
// as stimulus is driven and popped by a negedge monitor when the DUT produces them.
module tb_bus2_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int NB  = 8;
  localparam int TMO = 32;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0]      we = 2'b00;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      gnt, wtake, rvalid, done, err, m_cmd;
  logic [DW-1:0]   rdata, m_wdata;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_rvalid = 1'b0;
  logic            m_resp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] wbase [2];
  int            widx  [2];
  logic [63:0]   q_cmd [$];
  logic [63:0]   q_wr  [$];
  logic [63:0]   q_rd  [$];
  logic [63:0]   q_done[$];
  logic [53:0]   all_out;

  assign all_out = {gnt, wtake, rdata, rvalid, done, err, m_cmd, m_addr, m_wdata};

  bus2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .wtake(wtake), .rdata(rdata), .rvalid(rvalid), .done(done), .err(err),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_resp(m_resp)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int p);
    return 2'(1 << p);
  endfunction

  function automatic logic [63:0] mk_cmd(input int p, input logic [1:0] c, input logic [AW-1:0] a);
    return 64'({oh(p), c, a});
  endfunction

  task automatic upd_wdata();
    wdata = {wbase[1] + 16'(widx[1]), wbase[0] + 16'(widx[0])};
  endtask

  // Requesters advance their write beat on the cycle after a wtake.
  task automatic tick();
    logic [1:0] w;
    w = wtake;
    @(posedge CLK);
    #1;
    m_rvalid = 1'b0;
    m_resp   = 1'b0;
    for (int p = 0; p < 2; p++) if (w[p]) widx[p]++;
    upd_wdata();
  endtask

  task automatic wait_cmd();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_cmd != 2'd0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk("cmd_wait_expired", 64'(m_cmd), 64'(1));
  endtask

  task automatic serve_read(input int p, input logic [DW-1:0] base, input int lat, input bit keep);
    wait_cmd();
    q_done.push_back(64'({oh(p), 2'b00}));
    repeat (lat) tick();
    for (int i = 0; i < NB; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + 16'(i);
      q_rd.push_back(64'({oh(p), base + 16'(i)}));
      tick();
    end
    chk("rd_done_lat", 64'({done, err}), 64'({oh(p), 2'b00}));
    if (!keep) req[p] = 1'b0;
    tick();
  endtask

  task automatic serve_write(input int p, input int resp_dly, input bit keep);
    wait_cmd();
    for (int i = 0; i < NB; i++) q_wr.push_back(64'({oh(p), wbase[p] + 16'(i)}));
    q_done.push_back(64'({oh(p), 2'b00}));
    repeat (NB - 1 + resp_dly) tick();
    m_resp = 1'b1;
    tick();
    chk("wr_done_lat", 64'({done, err}), 64'({oh(p), 2'b00}));
    if (!keep) req[p] = 1'b0;
    tick();
  endtask

  always @(negedge CLK) begin
    if (m_cmd != 2'd0) begin
      if (q_cmd.size() == 0) chk("cmd_unexpected", 64'({gnt, m_cmd, m_addr}), 64'(0));
      else chk("cmd", 64'({gnt, m_cmd, m_addr}), q_cmd.pop_front());
    end
    if (wtake != 2'b00) begin
      if (q_wr.size() == 0) chk("wbeat_unexpected", 64'({wtake, m_wdata}), 64'(0));
      else chk("wbeat", 64'({wtake, m_wdata}), q_wr.pop_front());
    end
    if (rvalid != 2'b00) begin
      if (q_rd.size() == 0) chk("rbeat_unexpected", 64'({rvalid, rdata}), 64'(0));
      else chk("rbeat", 64'({rvalid, rdata}), q_rd.pop_front());
    end
    if (done != 2'b00) begin
      if (q_done.size() == 0) chk("done_unexpected", 64'({done, err}), 64'(0));
      else chk("done", 64'({done, err}), q_done.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wbase[0] = 16'h9000;
    wbase[1] = 16'hA000;
    widx[0]  = 0;
    widx[1]  = 0;
    upd_wdata();

    // Reset held with both ports requesting; port 0 must win first after release.
    RESET = 1'b0;
    req   = 2'b11;
    we    = 2'b10;
    addr  = {10'h3FF, 10'h005};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", 64'(all_out), 64'(0));
    end
    RESET = 1'b1;
    q_cmd.push_back(mk_cmd(0, 2'd2, 10'h005));
    q_cmd.push_back(mk_cmd(1, 2'd3, 10'h3FF));
    serve_read(0, 16'h1100, 10, 1'b0);
    serve_write(1, 20, 1'b0);

    // Both ports continuously requesting: grants must alternate.
    we   = 2'b00;
    addr = {10'h2B0, 10'h011};
    req  = 2'b11;
    q_cmd.push_back(mk_cmd(0, 2'd2, 10'h011));
    q_cmd.push_back(mk_cmd(1, 2'd2, 10'h2B0));
    q_cmd.push_back(mk_cmd(0, 2'd2, 10'h011));
    q_cmd.push_back(mk_cmd(1, 2'd2, 10'h2B0));
    serve_read(0, 16'h2000, 1, 1'b1);
    serve_read(1, 16'h3000, 1, 1'b1);
    serve_read(0, 16'h2100, 1, 1'b1);
    serve_read(1, 16'h3100, 1, 1'b1);
    req = 2'b00;
    tick();

    // Silent memory on a read: timeout abort exactly TMO cycles after ISSUE.
    addr[AW-1:0] = 10'h123;
    req = 2'b01;
    q_cmd.push_back(mk_cmd(0, 2'd2, 10'h123));
    wait_cmd();
    q_done.push_back(64'({2'b01, 2'b01}));
    repeat (TMO - 1) tick();
    chk("tmo_not_early", 64'(done), 64'(0));
    tick();
    chk("tmo_done", 64'({done, err}), 64'({2'b01, 2'b01}));
    req = 2'b00;
    tick();
    m_rvalid = 1'b1;
    m_rdata  = 16'hDEAD;
    #1;
    chk("late_rvalid", 64'({rvalid, rdata}), 64'(0));
    tick();

    // Asynchronous reset in the middle of a write burst, then a clean retry.
    we = 2'b10;
    addr[2*AW-1:AW] = 10'h0AA;
    wbase[1] = 16'hB000;
    widx[1]  = 0;
    upd_wdata();
    req = 2'b10;
    q_cmd.push_back(mk_cmd(1, 2'd3, 10'h0AA));
    wait_cmd();
    for (int i = 0; i < 4; i++) q_wr.push_back(64'({2'b10, 16'hB000 + 16'(i)}));
    repeat (4) tick();
    RESET = 1'b0;
    #1;
    chk("arst_out", 64'(all_out), 64'(0));
    tick();
    chk("arst_hold", 64'(all_out), 64'(0));
    widx[1] = 0;
    upd_wdata();
    RESET = 1'b1;
    q_cmd.push_back(mk_cmd(1, 2'd3, 10'h0AA));
    serve_write(1, 3, 1'b0);

    repeat (3) tick();
    chk("q_cmd_left", 64'(q_cmd.size()), 64'(0));
    chk("q_wr_left", 64'(q_wr.size()), 64'(0));
    chk("q_rd_left", 64'(q_rd.size()), 64'(0));
    chk("q_done_left", 64'(q_done.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
